mips_trace_buf: RTL and testbench

Trace capture buffer downstream of the single-cycle `mips` core. Samples the core's architectural write-back observation ports each cycle, turns every register write (excluding `$0`) and memory write into a 97-bit record, and queues the records in a first-word-fall-through FIFO. Records leave through a valid/ready port to the simulation checker or host logger. Losses are flagged and counted, never silent.

---
 rtl/mips_trace_pkg.sv | 33 +++
 rtl/trace_fifo.sv | 60 ++++++
 rtl/mips_trace_buf.sv | 86 ++++++++
 tb/tb_mips_trace_buf.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mips_trace_pkg.sv
// Shared record layout for the MIPS write-back trace buffer.
// A record is {kind, pc, addr, data}, kind in the MSB.
package mips_trace_pkg;

  localparam logic TRACE_KIND_REG = 1'b0;
  localparam logic TRACE_KIND_MEM = 1'b1;

  localparam int TRACE_REC_W    = 97;
  localparam int REC_DATA_LSB   = 0;
  localparam int REC_ADDR_LSB   = 32;
  localparam int REC_PC_LSB     = 64;
  localparam int REC_KIND_BIT   = 96;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_rec_t;

  function automatic trace_rec_t pack_rec(input logic        kind,
                                          input logic [31:0] pc,
                                          input logic [31:0] addr,
                                          input logic [31:0] data);
    trace_rec_t r;
    r.kind = kind;
    r.pc   = pc;
    r.addr = addr;
    r.data = data;
    return r;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO: head entry is visible combinationally.
// Occupancy is tracked separately from the pointers so full/empty are distinct.
module trace_fifo #(
  parameter int W     = 97,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     push_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pop;

  always_comb begin
    pop      = (count_q != '0) && rd_ready;
    // A full FIFO still takes a push when the head leaves on the same edge.
    push_ok  = push && ((count_q != (AW+1)'(DEPTH)) || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rd_valid = (count_q != '0);
  assign rdata    = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/mips_trace_buf.sv
// Captures register/memory write-backs of the mips core into trace records.
// Dropped events (full FIFO, or a same-cycle mem write) are flagged and counted.
module mips_trace_buf
  import mips_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              pc,
  input  logic                     RegWrite,
  input  logic [4:0]               RegAddr,
  input  logic [31:0]              RegData,
  input  logic                     MemWrite,
  input  logic [31:0]              MemAddr,
  input  logic [31:0]              MemData,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_kind,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_addr,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt
);

  logic             reg_ev, mem_ev, push_req, push_ok, fifo_valid;
  trace_rec_t       rec, head;
  logic [1:0]       drop_inc;
  logic [CNT_W:0]   drop_sum;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    reg_ev   = RegWrite && (RegAddr != 5'd0);
    mem_ev   = MemWrite;
    push_req = reg_ev || mem_ev;
    // The reg write wins when both fire; the mem record is lost.
    rec = reg_ev ? pack_rec(TRACE_KIND_REG, pc, {27'b0, RegAddr}, RegData)
                 : pack_rec(TRACE_KIND_MEM, pc, MemAddr, MemData);
  end

  trace_fifo #(.W(TRACE_REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_req),
    .wdata    (rec),
    .rd_ready (out_ready),
    .rd_valid (fifo_valid),
    .rdata    (head),
    .count    (count),
    .push_ok  (push_ok)
  );

  always_comb begin
    drop_inc = {1'b0, reg_ev && mem_ev} + {1'b0, push_req && !push_ok};
    drop_sum = {1'b0, drop_cnt_q} + (CNT_W+1)'(drop_inc);
    // Up to two drops per cycle; clamp at all-ones.
    drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    overflow_d = overflow_q || (drop_inc != 2'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    out_valid = fifo_valid;
    out_kind  = fifo_valid ? head.kind : 1'b0;
    out_pc    = fifo_valid ? head.pc   : 32'd0;
    out_addr  = fifo_valid ? head.addr : 32'd0;
    out_data  = fifo_valid ? head.data : 32'd0;
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_mips_trace_buf.sv
// Directed bench for mips_trace_buf: capture, drop accounting, streaming, reset.
module tb_mips_trace_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        RegWrite;
  logic [4:0]  RegAddr;
  logic [31:0] RegData;
  logic        MemWrite;
  logic [31:0] MemAddr;
  logic [31:0] MemData;
  logic        out_valid, out_ready, out_kind;
  logic [31:0] out_pc, out_addr, out_data;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mips_trace_buf #(.DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .pc(pc),
    .RegWrite(RegWrite), .RegAddr(RegAddr), .RegData(RegData),
    .MemWrite(MemWrite), .MemAddr(MemAddr), .MemData(MemData),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite = 0; RegAddr = 0; RegData = 0;
    MemWrite = 0; MemAddr = 0; MemData = 0; pc = 0;
  endtask

  task automatic set_reg(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    RegWrite = 1; RegAddr = a; RegData = d; pc = p;
  endtask

  task automatic test_reset();
    reset = 1; out_ready = 0; idle();
    step(); step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    tests++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if ({overflow, drop_cnt} !== 17'd0) begin fails++; $display("FAIL reset_drop got %b/%0d exp 0/0", overflow, drop_cnt); end
    reset = 0;
  endtask

  task automatic test_reg_write();
    set_reg(5'd8, 32'h1234, 32'h3000);
    step(); idle();
    tests++; if ({out_valid, out_kind, out_addr, out_data, out_pc} !== {1'b1, 1'b0, 32'd8, 32'h1234, 32'h3000})
      begin fails++; $display("FAIL reg_rec got v=%b k=%b a=%h d=%h pc=%h exp 1 0 8 1234 3000", out_valid, out_kind, out_addr, out_data, out_pc); end
    tests++; if (count !== 5'd1) begin fails++; $display("FAIL reg_count got %0d exp 1", count); end
    out_ready = 1; step(); out_ready = 0;
    tests++; if ({out_valid, out_data, count} !== {1'b0, 32'd0, 5'd0})
      begin fails++; $display("FAIL reg_pop got v=%b d=%h c=%0d exp 0 0 0", out_valid, out_data, count); end
  endtask

  task automatic test_zero_and_mem();
    set_reg(5'd0, 32'hFFFF, 32'h10);
    step(); idle();
    tests++; if (count !== 5'd0) begin fails++; $display("FAIL r0_count got %0d exp 0", count); end
    MemWrite = 1; MemAddr = 32'h4; MemData = 32'hDEADBEEF; pc = 32'h14;
    step(); idle();
    tests++; if ({out_valid, out_kind, out_addr, out_data, out_pc} !== {1'b1, 1'b1, 32'h4, 32'hDEADBEEF, 32'h14})
      begin fails++; $display("FAIL mem_rec got v=%b k=%b a=%h d=%h pc=%h exp 1 1 4 deadbeef 14", out_valid, out_kind, out_addr, out_data, out_pc); end
    out_ready = 1; step(); out_ready = 0;
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 18; i++) begin
      set_reg(5'(i), 32'h100 + 32'(i), 32'h1000 + 32'(4*i));
      step();
    end
    idle();
    tests++; if ({count, overflow, drop_cnt} !== {5'd16, 1'b1, 16'd2})
      begin fails++; $display("FAIL ovf_state got c=%0d o=%b d=%0d exp 16 1 2", count, overflow, drop_cnt); end
    out_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      tests++; if ({out_valid, out_data, out_addr} !== {1'b1, 32'h100 + 32'(i), 32'(i)})
        begin fails++; $display("FAIL drain_%0d got v=%b d=%h a=%h exp 1 %h %h", i, out_valid, out_data, out_addr, 32'h100 + 32'(i), i); end
      step();
    end
    out_ready = 0;
    tests++; if ({out_valid, count} !== {1'b0, 5'd0}) begin fails++; $display("FAIL drain_empty got v=%b c=%0d exp 0 0", out_valid, count); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 16; k++) begin
      set_reg(5'd9, 32'h200 + 32'(k), 32'h2000);
      step();
    end
    for (int j = 0; j < 8; j++) begin
      set_reg(5'd9, 32'h210 + 32'(j), 32'h2000);
      out_ready = 1;
      tests++; if (out_data !== 32'h200 + 32'(j)) begin fails++; $display("FAIL stream_head_%0d got %h exp %h", j, out_data, 32'h200 + 32'(j)); end
      step();
      tests++; if (count !== 5'd16) begin fails++; $display("FAIL stream_count_%0d got %0d exp 16", j, count); end
    end
    idle();
    for (int j = 8; j < 24; j++) begin
      tests++; if ({out_valid, out_data} !== {1'b1, 32'h200 + 32'(j)})
        begin fails++; $display("FAIL wrap_%0d got v=%b d=%h exp 1 %h", j, out_valid, out_data, 32'h200 + 32'(j)); end
      step();
    end
    out_ready = 0;
    tests++; if ({out_valid, drop_cnt} !== {1'b0, 16'd2}) begin fails++; $display("FAIL stream_end got v=%b d=%0d exp 0 2", out_valid, drop_cnt); end
  endtask

  task automatic test_dual_write();
    set_reg(5'd3, 32'hAA, 32'h4000);
    MemWrite = 1; MemAddr = 32'h80; MemData = 32'hBB;
    step(); idle();
    tests++; if ({count, out_kind, out_addr, out_data} !== {5'd1, 1'b0, 32'd3, 32'hAA})
      begin fails++; $display("FAIL dual_rec got c=%0d k=%b a=%h d=%h exp 1 0 3 aa", count, out_kind, out_addr, out_data); end
    tests++; if ({overflow, drop_cnt} !== {1'b1, 16'd3}) begin fails++; $display("FAIL dual_drop got o=%b d=%0d exp 1 3", overflow, drop_cnt); end
    out_ready = 1; step(); out_ready = 0;
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      set_reg(5'd7, 32'h70 + 32'(k), 32'h7000);
      step();
    end
    idle();
    out_ready = 1; step();
    #2 reset = 1;
    #1;
    tests++; if ({out_valid, out_kind, out_pc, out_addr, out_data, count, overflow, drop_cnt} !== '0)
      begin fails++; $display("FAIL async_reset got v=%b c=%0d d=%h o=%b dc=%0d exp all 0", out_valid, count, out_data, overflow, drop_cnt); end
    out_ready = 0;
    step();
    reset = 0;
    set_reg(5'd5, 32'h55, 32'h5000);
    step(); idle();
    tests++; if ({out_valid, out_data, out_pc, count} !== {1'b1, 32'h55, 32'h5000, 5'd1})
      begin fails++; $display("FAIL post_reset got v=%b d=%h pc=%h c=%0d exp 1 55 5000 1", out_valid, out_data, out_pc, count); end
  endtask

  initial begin
    test_reset();
    test_reg_write();
    test_zero_and_mem();
    test_overflow();
    test_back_to_back();
    test_dual_write();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
